// File: rtl/ysyx_23060184_ifu.sv
// Instruction fetch unit: holds the PC and fetches one instruction at a time over AR/R.
// It then hands the instruction to decode and accepts the next PC once decode has taken it.
`timescale 1ns/1ps
module ysyx_23060184_ifu #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  npc_valid,
  input  logic [DATA_WIDTH-1:0] npc,
  output logic                  npc_ready,
  output logic                  imem_arvalid,
  output logic [DATA_WIDTH-1:0] imem_araddr,
  input  logic                  imem_arready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic [1:0]            imem_rresp,
  output logic                  imem_rready,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  fetch_fault,
  output logic [31:0]           fetch_cnt
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_NEXT
  } state_t;

  state_t state, state_nxt;
  logic   misaligned;

  assign misaligned  = |pc[1:0];
  assign imem_araddr = pc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs depend only on registered state and pc, never on inputs.
  always_comb begin
    state_nxt    = state;
    imem_arvalid = 1'b0;
    imem_rready  = 1'b0;
    inst_valid   = 1'b0;
    npc_ready    = 1'b0;
    unique case (state)
      S_BOOT: state_nxt = S_REQ;
      S_REQ: begin
        imem_arvalid = !misaligned;
        if (misaligned) begin
          state_nxt = S_HOLD;
        end else if (imem_arready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        imem_rready = 1'b1;
        if (imem_rvalid) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        npc_ready = 1'b1;
        if (npc_valid) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc          <= RESET_PC;
      inst        <= '0;
      fetch_fault <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      if (state == S_REQ && misaligned) begin
        inst        <= '0;
        fetch_fault <= 1'b1;
      end
      // A bus error delivers a zero instruction so decode never sees garbage.
      if (imem_rready && imem_rvalid) begin
        fetch_fault <= |imem_rresp;
        inst        <= (|imem_rresp) ? '0 : imem_rdata;
      end
      if (inst_valid && inst_ready) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (npc_ready && npc_valid) begin
        pc          <= npc;
        fetch_fault <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ysyx_23060184_ifu.md
Name: ysyx_23060184_ifu

Overview:
Instruction fetch unit. Holds the architectural PC, fetches one instruction per PC over an AXI-lite-style read channel (AR/R) to instruction memory, and hands it to decode with a valid/ready handshake. It is the consumer of the next-PC generator: it accepts the next PC only after decode has taken the current instruction. The core is multi-cycle, so only one fetch is outstanding at a time.

Parameters:
DATA_WIDTH, 32, width of PC, address and instruction
RESET_PC, 32'h8000_0000, PC loaded on reset

Ports:
clk  input  1  core clock
resetn  input  1  asynchronous active-low reset
npc_valid  input  1  next PC presented by the next-PC generator
npc  input  DATA_WIDTH  next PC value
npc_ready  output  1  IFU accepts npc this cycle
imem_arvalid  output  1  read address valid
imem_araddr  output  DATA_WIDTH  read address, always equal to pc
imem_arready  input  1  memory accepts address
imem_rvalid  input  1  read data valid
imem_rdata  input  DATA_WIDTH  read data
imem_rresp  input  2  response, 2'b00 = OKAY, anything else = error
imem_rready  output  1  IFU accepts read data
inst_valid  output  1  inst/pc/fetch_fault valid to decode
inst_ready  input  1  decode accepts the instruction
inst  output  DATA_WIDTH  fetched instruction
pc  output  DATA_WIDTH  PC of inst
fetch_fault  output  1  access fault (bus error) or misaligned PC, qualified by inst_valid
fetch_cnt  output  32  count of instructions handed to decode

Behaviour:
- States: S_BOOT, S_REQ, S_WAIT, S_HOLD, S_NEXT. All state is reset asynchronously by resetn low. No other reset source exists.
- Reset values: state = S_BOOT, pc = RESET_PC, inst = 0, fetch_fault = 0, fetch_cnt = 0. All handshake outputs (arvalid, rready, inst_valid, npc_ready) are 0.
- S_BOOT: all handshake outputs are 0. Go to S_REQ on the next clock.
- S_REQ: imem_arvalid = 1, imem_araddr = pc.
  - If pc[1:0] != 0: do not assert arvalid. Set inst = 0 and fetch_fault = 1, then go to S_HOLD. This takes 1 cycle with no bus traffic.
  - If imem_arvalid && imem_arready: go to S_WAIT.
  - Otherwise stay in S_REQ. araddr stays stable and arvalid is not deasserted before the handshake completes.
- S_WAIT: imem_rready = 1.
  - On imem_rvalid: latch inst = imem_rdata and fetch_fault = (imem_rresp != 0), then go to S_HOLD.
  - On an error response, inst is forced to 0.
- S_HOLD: inst_valid = 1. inst, pc and fetch_fault stay stable until inst_ready.
  - On inst_valid && inst_ready: fetch_cnt increments (wraps at 2^32), go to S_NEXT.
- S_NEXT: npc_ready = 1.
  - On npc_valid: pc <= npc, fetch_fault <= 0, go to S_REQ.
  - npc_valid in any other state is ignored; the producer holds it until npc_ready.
- Outputs are decoded from state, so there is no combinational path from any input to any output.
- Best-case latency per instruction is 4 cycles: REQ, WAIT, HOLD, NEXT, each completing in the same cycle it is entered.
- Memory may assert arready before arvalid, and rvalid before rready. Only handshake cycles matter.
- rvalid outside S_WAIT is not consumed.
- Reset asserted mid-transaction (e.g. in S_WAIT) aborts it. After reset, fetch restarts from RESET_PC via S_BOOT. The memory side is reset by the same resetn, so a stale response is impossible.
- Width rules: pc and npc are full DATA_WIDTH. No incrementer lives here; PC+4 is the generator's job.

Test Plan:
1. Reset release, zero-wait memory returning 32'h00000013 at 0x80000000:
   - araddr = 0x80000000 on the 2nd cycle after reset release.
   - inst_valid with inst = 0x00000013 and pc = 0x80000000.
   - fetch_cnt = 1 after inst_ready.
2. Sequential fetch: npc = 0x80000004 offered in S_NEXT, memory arready delayed 3 cycles and rvalid delayed 2 cycles:
   - araddr holds 0x80000004 for all stall cycles.
   - inst delivered once; total 9 cycles from npc handshake to S_NEXT.
3. Decode backpressure: inst_ready low for 5 cycles:
   - inst, pc and inst_valid stay stable; fetch_cnt unchanged.
   - npc_ready stays 0 until the cycle after inst_ready.
4. Bus error: imem_rresp = 2'b10 on fetch of 0x80000100:
   - inst_valid with inst = 0, fetch_fault = 1, pc = 0x80000100.
   - The next npc clears fetch_fault.
5. Misaligned redirect: npc = 0x80000002:
   - No arvalid is asserted.
   - inst_valid with fetch_fault = 1 and pc = 0x80000002 one cycle after S_REQ.
6. resetn pulsed low while in S_WAIT with pc = 0x80000040:
   - Outputs return to reset values immediately.
   - The next fetch is issued to 0x80000000.
